// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared constants and types for the two-requester ALU arbiter
// and the alu it fronts (MIPS funct opcodes, requester count, request bundle).
package alu_arbiter_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [5:0] {
    ALU_OP_SLL  = 6'b000000,
    ALU_OP_SRL  = 6'b000010,
    ALU_OP_SRA  = 6'b000011,
    ALU_OP_ADD  = 6'b100000,
    ALU_OP_ADDU = 6'b100001,
    ALU_OP_SUB  = 6'b100010,
    ALU_OP_SUBU = 6'b100011,
    ALU_OP_AND  = 6'b100100,
    ALU_OP_OR   = 6'b100101,
    ALU_OP_XOR  = 6'b100110,
    ALU_OP_NOR  = 6'b100111
  } alu_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  op;
  } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake bundle for both requesters.
// master = requester/consumer side, slave = arbiter side.
interface alu_arbiter_if;

  logic        req0_valid;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic [5:0]  req0_op;
  logic        req0_ready;
  logic        resp0_valid;
  logic [31:0] resp0_c;
  logic        resp0_over;
  logic        resp0_ready;

  logic        req1_valid;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [5:0]  req1_op;
  logic        req1_ready;
  logic        resp1_valid;
  logic [31:0] resp1_c;
  logic        resp1_over;
  logic        resp1_ready;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op, resp0_ready,
    output req1_valid, req1_a, req1_b, req1_op, resp1_ready,
    input  req0_ready, resp0_valid, resp0_c, resp0_over,
    input  req1_ready, resp1_valid, resp1_c, resp1_over
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op, resp0_ready,
    input  req1_valid, req1_a, req1_b, req1_op, resp1_ready,
    output req0_ready, resp0_valid, resp0_c, resp0_over,
    output req1_ready, resp1_valid, resp1_c, resp1_over
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational MIPS-funct ALU. Shifts move B by A[4:0]. Over flags signed
// overflow for add/sub only; unsupported opcodes yield c=0, over=0.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  op,
  output logic [31:0] c,
  output logic        over
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // Result and overflow selection by opcode
  always_comb begin
    c    = '0;
    over = 1'b0;
    case (op)
      ALU_OP_ADD: begin
        c    = sum;
        over = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_OP_ADDU: c = sum;
      ALU_OP_SUB: begin
        c    = diff;
        over = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_OP_SUBU: c = diff;
      ALU_OP_SLL:  c = b << a[4:0];
      ALU_OP_SRL:  c = b >> a[4:0];
      ALU_OP_SRA:  c = $signed(b) >>> a[4:0];
      ALU_OP_AND:  c = a & b;
      ALU_OP_OR:   c = a | b;
      ALU_OP_XOR:  c = a ^ b;
      ALU_OP_NOR:  c = ~(a | b);
      default: begin
        c    = '0;
        over = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one alu; each owns a one-entry result slot.
// Optional: define ALU_ARB_RR_EN for round-robin arbitration, otherwise
// requester 0 has fixed priority.
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] resp_ready;
  logic [NUM_REQ-1:0] slot_free;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;

  logic [NUM_REQ-1:0] slot_valid;
  logic [31:0]        slot_c [NUM_REQ];
  logic [NUM_REQ-1:0] slot_over;
  logic               last_grant;

  alu_req_t    alu_in;
  logic [31:0] alu_c;
  logic        alu_over;

  assign req_valid  = {bus.req1_valid, bus.req0_valid};
  assign resp_ready = {bus.resp1_ready, bus.resp0_ready};

  // Slot is free when empty or being drained this cycle
  always_comb begin
    slot_free = ~slot_valid | resp_ready;
    elig      = req_valid & slot_free;
  end

  // Grant selection among eligible requesters (operand values never involved)
  always_comb begin
    grant = '0;
`ifdef ALU_ARB_RR_EN
    if (elig == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end else begin
      grant = elig;
    end
`else
    if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
`endif
    accept = reset ? '0 : grant;
  end

  assign bus.req0_ready = accept[0];
  assign bus.req1_ready = accept[1];

  // Steer the granted requester's operands into the shared alu
  always_comb begin
    if (grant[1]) begin
      alu_in = '{a: bus.req1_a, b: bus.req1_b, op: bus.req1_op};
    end else begin
      alu_in = '{a: bus.req0_a, b: bus.req0_b, op: bus.req0_op};
    end
  end

  alu u_alu (
    .a    (alu_in.a),
    .b    (alu_in.b),
    .op   (alu_in.op),
    .c    (alu_c),
    .over (alu_over)
  );

  // Result slots and arbitration history; refill takes precedence over drain
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      slot_over  <= '0;
      last_grant <= 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        slot_c[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (accept[i]) begin
          slot_valid[i] <= 1'b1;
          slot_c[i]     <= alu_c;
          slot_over[i]  <= alu_over;
        end else if (resp_ready[i]) begin
          slot_valid[i] <= 1'b0;
        end
      end
      if (|accept) begin
        last_grant <= accept[1];
      end
    end
  end

  assign bus.resp0_valid = slot_valid[0];
  assign bus.resp0_c     = slot_c[0];
  assign bus.resp0_over  = slot_over[0];
  assign bus.resp1_valid = slot_valid[1];
  assign bus.resp1_c     = slot_c[1];
  assign bus.resp1_over  = slot_over[1];

  // last_grant must track the most recent acceptance
  a_last_grant_0: assert property (@(posedge clk) disable iff (reset)
    accept[0] |=> !last_grant);
  a_last_grant_1: assert property (@(posedge clk) disable iff (reset)
    accept[1] |=> last_grant);
  a_one_hot: assert property (@(posedge clk) $onehot0(accept));

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

`ifdef ALU_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.req0_valid  = 1'b0;
    bus.req0_a      = '0;
    bus.req0_b      = '0;
    bus.req0_op     = '0;
    bus.resp0_ready = 1'b1;
    bus.req1_valid  = 1'b0;
    bus.req1_a      = '0;
    bus.req1_b      = '0;
    bus.req1_op     = '0;
    bus.resp1_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL rst_ready0 got=%b exp=0", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL rst_ready1 got=%b exp=0", bus.req1_ready); end
    @(posedge clk); #1;
    total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL rst_valid0 got=%b exp=0", bus.resp0_valid); end
    total++; if (bus.resp1_valid !== 1'b0) begin bad++; $display("FAIL rst_valid1 got=%b exp=0", bus.resp1_valid); end
    total++; if (bus.resp0_c !== 32'h0) begin bad++; $display("FAIL rst_c0 got=%h exp=0", bus.resp0_c); end
    total++; if (bus.resp1_c !== 32'h0) begin bad++; $display("FAIL rst_c1 got=%h exp=0", bus.resp1_c); end
    total++; if (bus.resp0_over !== 1'b0) begin bad++; $display("FAIL rst_over0 got=%b exp=0", bus.resp0_over); end
    total++; if (bus.resp1_over !== 1'b0) begin bad++; $display("FAIL rst_over1 got=%b exp=0", bus.resp1_over); end
    clear_inputs();
    reset = 1'b0;
  endtask

  task automatic test_add_overflow();
    bus.req0_a = 32'h7FFFFFFF; bus.req0_b = 32'h00000001; bus.req0_op = 6'b100000;
    bus.req0_valid = 1'b1;
    @(negedge clk);
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL add_ready0 got=%b exp=1", bus.req0_ready); end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    total++; if (bus.resp0_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", bus.resp0_valid); end
    total++; if (bus.resp0_c !== 32'h80000000) begin bad++; $display("FAIL add_c got=%h exp=80000000", bus.resp0_c); end
    total++; if (bus.resp0_over !== 1'b1) begin bad++; $display("FAIL add_over got=%b exp=1", bus.resp0_over); end
    @(posedge clk); #1;
    total++; if (bus.resp0_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", bus.resp0_valid); end
  endtask

  task automatic test_sub_overflow();
    bus.req0_a = 32'h80000000; bus.req0_b = 32'h00000001; bus.req0_op = 6'b100010;
    bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    total++; if (bus.resp0_c !== 32'h7FFFFFFF) begin bad++; $display("FAIL sub_c got=%h exp=7fffffff", bus.resp0_c); end
    total++; if (bus.resp0_over !== 1'b1) begin bad++; $display("FAIL sub_over got=%b exp=1", bus.resp0_over); end
    @(posedge clk); #1;
  endtask

  task automatic test_sra();
    bus.req1_a = 32'h00000004; bus.req1_b = 32'hF0000000; bus.req1_op = 6'b000011;
    bus.req1_valid = 1'b1;
    @(negedge clk);
    total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL sra_ready1 got=%b exp=1", bus.req1_ready); end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    total++; if (bus.resp1_valid !== 1'b1) begin bad++; $display("FAIL sra_valid got=%b exp=1", bus.resp1_valid); end
    total++; if (bus.resp1_c !== 32'hFF000000) begin bad++; $display("FAIL sra_c got=%h exp=ff000000", bus.resp1_c); end
    total++; if (bus.resp1_over !== 1'b0) begin bad++; $display("FAIL sra_over got=%b exp=0", bus.resp1_over); end
    @(posedge clk); #1;
  endtask

  task automatic test_logic_ops();
    bus.req0_a = 32'h0F0F00FF; bus.req0_b = 32'h00FF0F0F; bus.req0_op = 6'b100111;
    bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.resp0_c !== 32'hF000F000) begin bad++; $display("FAIL nor_c got=%h exp=f000f000", bus.resp0_c); end
    bus.req0_a = 32'h00000008; bus.req0_b = 32'h000000AB; bus.req0_op = 6'b000000;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    total++; if (bus.resp0_c !== 32'h0000AB00) begin bad++; $display("FAIL sll_c got=%h exp=0000ab00", bus.resp0_c); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsupported();
    bus.req1_a = 32'h00000005; bus.req1_b = 32'h00000006; bus.req1_op = 6'b111111;
    bus.req1_valid = 1'b1;
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    total++; if (bus.resp1_valid !== 1'b1) begin bad++; $display("FAIL unsup_valid got=%b exp=1", bus.resp1_valid); end
    total++; if (bus.resp1_c !== 32'h0) begin bad++; $display("FAIL unsup_c got=%h exp=0", bus.resp1_c); end
    total++; if (bus.resp1_over !== 1'b0) begin bad++; $display("FAIL unsup_over got=%b exp=0", bus.resp1_over); end
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    logic [1:0]  exp_rdy;
    logic [31:0] exp_c;
    int          g;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
    bus.req0_valid = 1'b1; bus.req0_op = 6'b100000; bus.req0_b = 32'd1;
    bus.req1_valid = 1'b1; bus.req1_op = 6'b100000; bus.req1_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      bus.req0_a = 32'(i * 16);
      bus.req1_a = 32'(i * 16 + 8);
      g = RR ? (i % 2) : 0;
      exp_rdy = (g == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      total++; if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin bad++; $display("FAIL arb_grant[%0d] got=%b exp=%b", i, {bus.req1_ready, bus.req0_ready}, exp_rdy); end
      @(posedge clk); #1;
      if (g == 0) begin
        exp_c = 32'(i * 16 + 1);
        total++; if (bus.resp0_valid !== 1'b1 || bus.resp0_c !== exp_c) begin bad++; $display("FAIL arb_res0[%0d] got=%b/%h exp=1/%h", i, bus.resp0_valid, bus.resp0_c, exp_c); end
      end else begin
        exp_c = 32'(i * 16 + 10);
        total++; if (bus.resp1_valid !== 1'b1 || bus.resp1_c !== exp_c) begin bad++; $display("FAIL arb_res1[%0d] got=%b/%h exp=1/%h", i, bus.resp1_valid, bus.resp1_c, exp_c); end
      end
    end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    clear_inputs();
    bus.resp0_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd2; bus.req0_op = 6'b100000;
    @(negedge clk);
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL bp_fill_ready got=%b exp=1", bus.req0_ready); end
    @(posedge clk); #1;
    total++; if (bus.resp0_c !== 32'd3) begin bad++; $display("FAIL bp_fill_c got=%h exp=3", bus.resp0_c); end
    bus.req0_a = 32'h100; bus.req0_b = 32'h0;
    bus.req1_valid = 1'b1; bus.req1_b = 32'd1; bus.req1_op = 6'b100000;
    for (int k = 0; k < 3; k++) begin
      bus.req1_a = 32'(k + 20);
      @(negedge clk);
      total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL bp_ready0[%0d] got=%b exp=0", k, bus.req0_ready); end
      total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL bp_ready1[%0d] got=%b exp=1", k, bus.req1_ready); end
      @(posedge clk); #1;
      total++; if (bus.resp0_valid !== 1'b1 || bus.resp0_c !== 32'd3) begin bad++; $display("FAIL bp_hold0[%0d] got=%b/%h exp=1/3", k, bus.resp0_valid, bus.resp0_c); end
      total++; if (bus.resp1_c !== 32'(k + 21)) begin bad++; $display("FAIL bp_res1[%0d] got=%h exp=%h", k, bus.resp1_c, 32'(k + 21)); end
    end
    bus.resp0_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL bp_release0 got=%b exp=1", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL bp_release1 got=%b exp=0", bus.req1_ready); end
    @(posedge clk); #1;
    total++; if (bus.resp0_valid !== 1'b1 || bus.resp0_c !== 32'h100) begin bad++; $display("FAIL bp_refill got=%b/%h exp=1/100", bus.resp0_valid, bus.resp0_c); end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = 6'b100000;
    @(posedge clk); #1;
    total++; if (bus.resp0_valid !== 1'b1) begin bad++; $display("FAIL mid_accept got=%b exp=1", bus.resp0_valid); end
    reset = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_op = 6'b100000;
    @(negedge clk);
    total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready0 got=%b exp=0", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready1 got=%b exp=0", bus.req1_ready); end
    @(posedge clk); #1;
    total++; if (bus.resp0_valid !== 1'b0 || bus.resp0_c !== 32'h0) begin bad++; $display("FAIL mid_rst_slot0 got=%b/%h exp=0/0", bus.resp0_valid, bus.resp0_c); end
    total++; if (bus.resp1_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_slot1 got=%b exp=0", bus.resp1_valid); end
    reset = 1'b0;
    @(negedge clk);
    total++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin bad++; $display("FAIL mid_first_grant got=%b exp=01", {bus.req1_ready, bus.req0_ready}); end
    @(posedge clk); #1;
    total++; if (bus.resp0_c !== 32'd2) begin bad++; $display("FAIL mid_first_res got=%h exp=2", bus.resp0_c); end
    clear_inputs();
    @(posedge clk); #1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_add_overflow();
    test_sub_overflow();
    test_sra();
    test_logic_ops();
    test_unsupported();
    test_arbitration();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
